// File: rtl/processor_pkg.sv
// Shared processor definitions: instruction fields, opcodes
// and the fetch state encoding.
package processor_pkg;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int RDEST_MSB  = 11;
    localparam int RDEST_LSB  = 8;
    localparam int EXOP_MSB   = 7;
    localparam int EXOP_LSB   = 4;
    localparam int RSRC_MSB   = 3;
    localparam int RSRC_LSB   = 0;
    localparam int IMM_MSB    = 7;
    localparam int IMM_LSB    = 0;

    localparam logic [3:0] OP_RTYPE  = 4'h0;
    localparam logic [3:0] OP_ADDI   = 4'h5;
    localparam logic [3:0] OP_LOAD   = 4'h4;
    localparam logic [3:0] OP_STORE  = 4'h8;
    localparam logic [3:0] OP_BRANCH = 4'hC;

    localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [3:0] op_code(input logic [15:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: control-unit handshake plus instruction memory port.
// master = fetch unit, slave = control unit / memory side.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              pcEnabled;
    logic              branchMux;
    logic [ADDR_W-1:0] branchTarget;
    logic [ADDR_W-1:0] memAddr;
    logic              memEnabled;
    logic [15:0]       memData;
    logic [15:0]       instruction;
    logic              instrValid;
    logic [ADDR_W-1:0] pc;
    logic              protocolError;

    modport master (
        input  pcEnabled, branchMux, branchTarget, memData,
        output memAddr, memEnabled, instruction, instrValid,
        output pc, protocolError
    );

    modport slave (
        output pcEnabled, branchMux, branchTarget, memData,
        input  memAddr, memEnabled, instruction, instrValid,
        input  pc, protocolError
    );
endinterface

// File: rtl/fetch_pc_register.sv
// Program counter: reset load, wrapping increment, branch select.
module fetch_pc_register #(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              advance_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o
);
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (advance_i) begin
            pc_d = branch_i ? target_i : pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch FSM: reads one word per retire pulse and holds it
// stable for the control unit.
module instruction_fetch_unit
    import processor_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [15:0]       NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);
    fetch_state_e      state_q;
    logic [15:0]       instr_q;
    logic              valid_q;
    logic              err_q;
    logic              advance;
    logic [ADDR_W-1:0] pc;

    // Only a pulse seen while holding a word may move the PC.
    assign advance = (state_q == S_HOLD) && bus.pcEnabled;

    fetch_pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i     (clock),
        .rst_ni    (reset),
        .advance_i (advance),
        .branch_i  (bus.branchMux),
        .target_i  (bus.branchTarget),
        .pc_o      (pc)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_FETCH;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    state_q <= S_WAIT;
                    if (bus.pcEnabled) err_q <= 1'b1;
                end
                S_WAIT: begin
                    instr_q <= bus.memData;
                    valid_q <= 1'b1;
                    state_q <= S_HOLD;
                    if (bus.pcEnabled) err_q <= 1'b1;
                end
                S_HOLD: begin
                    if (bus.pcEnabled) begin
                        instr_q <= NOP_WORD;
                        valid_q <= 1'b0;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign bus.memEnabled    = (state_q == S_FETCH);
    assign bus.memAddr       = pc;
    assign bus.pc            = pc;
    assign bus.instruction   = instr_q;
    assign bus.instrValid    = valid_q;
    assign bus.protocolError = err_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a word scoreboard.
module tb_instruction_fetch_unit;
    import processor_pkg::*;

    localparam int AW = 16;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] word;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    instruction_fetch_unit_if #(.ADDR_W(AW)) bus ();

    instruction_fetch_unit #(
        .ADDR_W   (AW),
        .RESET_PC (16'h0000),
        .NOP_WORD (16'h0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [0:65535];
    always @(posedge clock) begin
        if (bus.memEnabled === 1'b1) bus.memData <= mem[bus.memAddr];
    end

    exp_t sb[$];
    exp_t e;
    int   compared   = 0;
    int   mismatched = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Each new valid word must match the oldest outstanding fetch.
    always @(negedge clock) begin
        if (bus.instrValid === 1'b1 && prev_valid !== 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_word", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("sb_word", bus.instruction, e.word);
                check("sb_pc", bus.pc, e.pc);
            end
        end
        prev_valid = bus.instrValid;
    end

    task automatic retire(input bit br, input logic [15:0] tgt,
                          input logic [15:0] exp_pc);
        bus.pcEnabled    = 1'b1;
        bus.branchMux    = br;
        bus.branchTarget = tgt;
        sb.push_back(exp_t'{exp_pc, mem[exp_pc]});
        @(negedge clock);
        bus.pcEnabled = 1'b0;
        bus.branchMux = 1'b0;
        check("fetch_en", bus.memEnabled, 1);
        check("fetch_addr", bus.memAddr, exp_pc);
        check("fetch_valid", bus.instrValid, 0);
    endtask

    task automatic await_word(input logic [15:0] w, input logic [15:0] p);
        repeat (2) @(negedge clock);
        check("word_valid", bus.instrValid, 1);
        check("word_data", bus.instruction, w);
        check("word_pc", bus.pc, p);
    endtask

    initial begin
        bus.pcEnabled    = 1'b0;
        bus.branchMux    = 1'b0;
        bus.branchTarget = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 7 + 16'h1111);
        mem[16'h0000] = 16'h0052;
        mem[16'h0001] = 16'h5408;
        mem[16'h0040] = 16'h4F00;
        mem[16'hFFFF] = 16'hC3A5;

        // reset and first fetch
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_valid", bus.instrValid, 0);
        check("rst_instr", bus.instruction, 16'h0000);
        check("rst_pc", bus.pc, 16'h0000);
        check("rst_addr", bus.memAddr, 16'h0000);
        check("rst_err", bus.protocolError, 0);
        reset = 1'b1;
        sb.push_back(exp_t'{16'h0000, mem[0]});
        check("first_en", bus.memEnabled, 1);
        check("first_addr", bus.memAddr, 16'h0000);
        await_word(16'h0052, 16'h0000);

        // sequential advance
        retire(1'b0, 16'h0000, 16'h0001);
        await_word(16'h5408, 16'h0001);

        // branchMux without pcEnabled changes nothing
        bus.branchMux    = 1'b1;
        bus.branchTarget = 16'h0099;
        repeat (3) @(negedge clock);
        check("hold_pc", bus.pc, 16'h0001);
        check("hold_instr", bus.instruction, 16'h5408);
        check("hold_valid", bus.instrValid, 1);
        bus.branchMux = 1'b0;

        // branch
        retire(1'b1, 16'h0040, 16'h0040);
        await_word(16'h4F00, 16'h0040);

        // wrap-around
        retire(1'b1, 16'hFFFF, 16'hFFFF);
        await_word(16'hC3A5, 16'hFFFF);
        retire(1'b0, 16'h0000, 16'h0000);
        check("wrap_pc", bus.pc, 16'h0000);
        await_word(16'h0052, 16'h0000);

        // protocol error: pulse during S_WAIT is ignored
        retire(1'b0, 16'h0000, 16'h0001);
        @(negedge clock);
        bus.pcEnabled    = 1'b1;
        bus.branchMux    = 1'b1;
        bus.branchTarget = 16'h1234;
        @(negedge clock);
        bus.pcEnabled = 1'b0;
        bus.branchMux = 1'b0;
        check("perr_set", bus.protocolError, 1);
        check("perr_pc", bus.pc, 16'h0001);
        check("perr_valid", bus.instrValid, 1);
        check("perr_instr", bus.instruction, 16'h5408);
        repeat (10) @(negedge clock);
        check("perr_sticky", bus.protocolError, 1);
        check("perr_pc_late", bus.pc, 16'h0001);

        // reset asserted mid-fetch
        retire(1'b1, 16'h0040, 16'h0040);
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        @(negedge clock);
        check("mrst_valid", bus.instrValid, 0);
        check("mrst_instr", bus.instruction, 16'h0000);
        check("mrst_pc", bus.pc, 16'h0000);
        check("mrst_err", bus.protocolError, 0);
        reset = 1'b1;
        sb.push_back(exp_t'{16'h0000, mem[0]});
        check("mrst_en", bus.memEnabled, 1);
        check("mrst_addr", bus.memAddr, 16'h0000);
        await_word(16'h0052, 16'h0000);

        retire(1'b0, 16'h0000, 16'h0001);
        await_word(16'h5408, 16'h0001);
        check("err_clear_kept", bus.protocolError, 0);

        @(negedge clock);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
